// File: rtl/pipelined_multiplier.sv
`timescale 1ns/1ps
// Purpose: RV32M-style multiply unit (MUL/MULH/MULHSU/MULHU) as a p_stages-deep slot pipeline from decode to writeback.
// Latency: an instruction accepted on edge t is presented on W after edge t+p_stages-1; one result per cycle when unstalled.
// Backpressure: slot ready ripples back from w_rdy; empty slots collapse bubbles; d_rdy drops only when every slot is full and w_rdy=0.
module pipelined_multiplier #(
  parameter int p_stages       = 2,
  parameter int p_addr_bits    = 32,
  parameter int p_data_bits    = 32,
  parameter int p_seq_num_bits = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // decode side
  input  logic                      d_val,
  output logic                      d_rdy,
  input  logic [p_addr_bits-1:0]    d_pc,
  input  logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic [p_data_bits-1:0]    d_op1,
  input  logic [p_data_bits-1:0]    d_op2,
  input  logic [4:0]                d_waddr,
  input  logic [3:0]                d_uop,
  // writeback side
  output logic                      w_val,
  input  logic                      w_rdy,
  output logic [p_addr_bits-1:0]    w_pc,
  output logic [p_seq_num_bits-1:0] w_seq_num,
  output logic [4:0]                w_waddr,
  output logic [p_data_bits-1:0]    w_wdata,
  output logic                      w_wen
);

  // rv_uop encodings handled by this unit; every other code passes through as a no-write bubble.
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;

  localparam int LAST = p_stages - 1;
  localparam int W    = p_data_bits;

  logic [p_stages-1:0]       vld_q;
  logic [p_stages-1:0]       rdy;
  logic [p_addr_bits-1:0]    pc_q    [p_stages];
  logic [p_seq_num_bits-1:0] seq_q   [p_stages];
  logic [4:0]                waddr_q [p_stages];
  logic [3:0]                uop_q   [p_stages];

  // Slot 0 keeps the raw operands; the product is formed from these registers.
  logic [W-1:0]   op1_q;
  logic [W-1:0]   op2_q;
  logic           op1_sgn;
  logic           op2_sgn;
  logic [2*W-1:0] op1_ext;
  logic [2*W-1:0] op2_ext;
  logic [2*W-1:0] prod;
  logic [W-1:0]   res0;

  function automatic logic is_supported(input logic [3:0] uop);
    return (uop == OP_MUL) || (uop == OP_MULH) || (uop == OP_MULHSU) || (uop == OP_MULHU);
  endfunction

  // Slot i can take new content if it or any later slot is empty, or writeback drains this cycle.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < p_stages; i++) begin
      rdy[i] = w_rdy || !(&(vld_q | p_stages'((1 << i) - 1)));
    end
  end

  assign d_rdy = rdy[0];

  // Valid bits: the only reset state; cleared asynchronously so in-flight work is discarded at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (rdy[0]) vld_q[0] <= d_val;
      for (int i = 1; i < p_stages; i++) begin
        if (rdy[i]) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Sideband fields and operands follow the valid bits without reset.
  always_ff @(posedge clk) begin
    if (rdy[0]) begin
      pc_q[0]    <= d_pc;
      seq_q[0]   <= d_seq_num;
      waddr_q[0] <= d_waddr;
      uop_q[0]   <= d_uop;
      op1_q      <= d_op1;
      op2_q      <= d_op2;
    end
    for (int i = 1; i < p_stages; i++) begin
      if (rdy[i]) begin
        pc_q[i]    <= pc_q[i-1];
        seq_q[i]   <= seq_q[i-1];
        waddr_q[i] <= waddr_q[i-1];
        uop_q[i]   <= uop_q[i-1];
      end
    end
  end

  // Full-width product of the slot-0 operands, then pick the half the uop asks for.
  always_comb begin
    op1_sgn = (uop_q[0] == OP_MULH) || (uop_q[0] == OP_MULHSU);
    op2_sgn = (uop_q[0] == OP_MULH);
    op1_ext = {{W{op1_sgn & op1_q[W-1]}}, op1_q};
    op2_ext = {{W{op2_sgn & op2_q[W-1]}}, op2_q};
    prod    = op1_ext * op2_ext;
    res0    = '0;
    case (uop_q[0])
      OP_MUL:                       res0 = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res0 = prod[2*W-1:W];
      default:                      res0 = '0;
    endcase
  end

  generate
    if (p_stages == 1) begin : g_single
      assign w_wdata = res0;
    end else begin : g_multi
      // res_q[k] is the result carried by slot k+1.
      logic [W-1:0] res_q [p_stages-1];

      // Results enter slot 1 from the multiplier and then shift with the slot sideband.
      always_ff @(posedge clk) begin
        if (rdy[1]) res_q[0] <= res0;
        for (int i = 2; i < p_stages; i++) begin
          if (rdy[i]) res_q[i-1] <= res_q[i-2];
        end
      end

      assign w_wdata = res_q[p_stages-2];
    end
  endgenerate

  assign w_val     = vld_q[LAST];
  assign w_pc      = pc_q[LAST];
  assign w_seq_num = seq_q[LAST];
  assign w_waddr   = waddr_q[LAST];
  assign w_wen     = vld_q[LAST] && is_supported(uop_q[LAST]);

endmodule

// File: doc/pipelined_multiplier.md
PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

Interface
REQ-001 Parameter p_stages, default 2: number of register stages from D acceptance to W presentation; legal range 1..8.
REQ-002 Parameter p_addr_bits, default taken from D interface: PC width.
REQ-003 Parameter p_data_bits, default taken from D interface: operand and result width.
REQ-004 Parameter p_seq_num_bits, default taken from D interface: sequence number width.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 D.val  input  1  decode presents a valid instruction.
REQ-008 D.rdy  output  1  unit can accept an instruction this cycle.
REQ-009 D.pc  input  p_addr_bits  instruction PC.
REQ-010 D.seq_num  input  p_seq_num_bits  instruction sequence number.
REQ-011 D.op1, D.op2  input  p_data_bits each  source operands.
REQ-012 D.waddr  input  5  destination register.
REQ-013 D.uop  input  rv_uop  micro-op.
REQ-014 W.val  output  1  result valid toward writeback.
REQ-015 W.rdy  input  1  writeback accepts this cycle.
REQ-016 W.pc, W.seq_num, W.waddr  output  widths as D  carried with the result.
REQ-017 W.wdata  output  p_data_bits  result.
REQ-018 W.wen  output  1  register write enable.

Function
REQ-019 D transfer SHALL occur when D.val & D.rdy on a rising edge; W transfer when W.val & W.rdy.
REQ-020 Pipeline SHALL hold p_stages slots; each slot has a valid bit plus pc, seq_num, waddr, uop and data.
REQ-021 Slot i SHALL be ready when empty or when slot i+1 is ready; last slot ready = W.rdy; D.rdy SHALL equal slot-0 ready.
REQ-022 Bubbles SHALL collapse: a valid slot advances whenever the next slot is empty, independent of W.rdy.
REQ-023 Uncongested latency: an instruction accepted at edge t SHALL appear on W (W.val=1) in the cycle after edge t+p_stages-1; p_stages=1 gives next-cycle presentation.
REQ-024 Throughput SHALL be one instruction per cycle while W.rdy=1; results SHALL leave in acceptance order, never dropped or duplicated.
REQ-025 Simultaneous D transfer and W transfer in the same cycle with a full pipeline SHALL be legal and lossless.
REQ-026 W.val SHALL equal the last slot's valid bit; W.pc/seq_num/waddr SHALL be the last slot's fields and SHALL stay stable while W.val & !W.rdy.
REQ-027 OP_MUL: wdata = low p_data_bits of op1*op2 (wraps, no overflow flag).
REQ-028 OP_MULH: wdata = high p_data_bits of signed(op1)*signed(op2), full 2*p_data_bits product.
REQ-029 OP_MULHSU: high p_data_bits of signed(op1)*unsigned(op2).
REQ-030 OP_MULHU: high p_data_bits of unsigned(op1)*unsigned(op2).
REQ-031 Any other uop SHALL still flow through the pipeline with wdata=0 and wen=0; supported uops give wen=1.
REQ-032 Product SHALL be formed from registered operands; internal split of the multiply across stages is free provided REQ-023..030 hold.
REQ-033 Outputs when W.val=0: wdata, pc, seq_num, waddr are don't-care; wen SHALL be 0.

Reset
REQ-034 rst_n low SHALL clear all slot valid bits asynchronously, without waiting for clk.
REQ-035 During reset: W.val=0, W.wen=0, D.rdy=1; data fields are not reset.
REQ-036 Reset mid-operation SHALL discard all in-flight instructions; none SHALL appear on W after release.
REQ-037 First D transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification (p_data_bits=32, p_stages=3 unless noted)
REQ-038 MUL op1=7, op2=6, seq_num=5, waddr=3, W.rdy=1 -> W.val in the third cycle after acceptance, wdata=42, seq_num=5, waddr=3, wen=1.
REQ-039 op1=0xFFFFFFFF, op2=2: MULH -> 0xFFFFFFFF; MULHSU -> 0xFFFFFFFF; MULHU -> 0x00000001; MUL -> 0xFFFFFFFE.
REQ-040 Eight back-to-back MULs (seq 0..7), W.rdy=1 -> eight consecutive W transfers, seq 0..7 in order, no gap.
REQ-041 Pipeline full, W.rdy=0 for 4 cycles -> D.rdy=0 throughout, W fields stable; on W.rdy=1 drain in order with no loss or duplicate.
REQ-042 Two instructions in flight, rst_n pulsed low between clock edges -> W.val falls immediately; after release W.val stays 0 until a new D transfer.
REQ-043 p_stages=1, MUL 0x80000000*2 -> wdata=0x00000000 in the cycle after acceptance; unsupported uop -> wen=0, wdata=0.
